// File: rtl/nn_pkg.sv
// Shared sign-magnitude widths, saturation limit and FSM state encoding for the neuron datapath.
// Latency: none (declarations and a pure packing helper only).
// Backpressure: not applicable.
package nn_pkg;

  localparam int SM_W     = 21;
  localparam int SIGN_BIT = 20;
  localparam int MAG_W    = 20;

  localparam logic [MAG_W-1:0] SM_MAX_MAG = 20'hFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FIN  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Build a sign-magnitude word from its two fields.
  function automatic logic [SM_W-1:0] sm_pack(input logic sgn, input logic [MAG_W-1:0] mag);
    return {sgn, mag};
  endfunction

endpackage

// File: rtl/Adder16.sv
// Combinational 21-bit sign-magnitude adder; cout is the carry out of the magnitude MSB.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the result is used.
module Adder16
  import nn_pkg::*;
(
  input  logic [SM_W-1:0] a,
  input  logic [SM_W-1:0] b,
  output logic [SM_W-1:0] sum,
  output logic            cout
);

  logic             a_sgn;
  logic             b_sgn;
  logic [MAG_W-1:0] a_mag;
  logic [MAG_W-1:0] b_mag;
  logic [MAG_W:0]   mag_add;

  assign a_sgn = a[SIGN_BIT];
  assign b_sgn = b[SIGN_BIT];
  assign a_mag = a[MAG_W-1:0];
  assign b_mag = b[MAG_W-1:0];

  // Equal signs add magnitudes; unequal signs subtract the smaller from the larger.
  // A zero-magnitude difference keeps a's sign; callers normalise it later.
  always_comb begin
    sum     = '0;
    cout    = 1'b0;
    mag_add = '0;
    if (a_sgn == b_sgn) begin
      mag_add = {1'b0, a_mag} + {1'b0, b_mag};
      sum     = sm_pack(a_sgn, mag_add[MAG_W-1:0]);
      cout    = mag_add[MAG_W];
    end else if (a_mag >= b_mag) begin
      sum = sm_pack(a_sgn, a_mag - b_mag);
    end else begin
      sum = sm_pack(b_sgn, b_mag - a_mag);
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates one neuron: bias plus a stream of sign-magnitude products, saturating, optional ReLU.
// Latency: result valid two cycles after the cycle carrying the last term handshake.
// Backpressure: result and ovf held in OUT until out_ready; in_ready is 1 only in ACC.
module neuron_accumulator
  import nn_pkg::*;
#(
  parameter logic RELU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SM_W-1:0] bias,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SM_W-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SM_W-1:0] out_data,
  output logic            busy,
  output logic            ovf
);

  state_t          state;
  state_t          state_nxt;
  logic [SM_W-1:0] acc;
  logic [SM_W-1:0] add_sum;
  logic            add_cout;
  logic            add_ovf;
  logic [SM_W-1:0] sat_sum;
  logic            in_hs;

  Adder16 u_adder (
    .a    (acc),
    .b    (in_data),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Only same-sign adds can run past the magnitude range; clamp to full scale keeping the sign.
  assign add_ovf = (acc[SIGN_BIT] == in_data[SIGN_BIT]) & add_cout;
  assign sat_sum = add_ovf ? sm_pack(acc[SIGN_BIT], SM_MAX_MAG) : add_sum;

  assign in_hs     = in_valid & in_ready;
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);

  // Drop the sign of a zero magnitude, then clip negatives to zero when ReLU is enabled.
  function automatic logic [SM_W-1:0] act_norm(input logic [SM_W-1:0] v);
    if (v[MAG_W-1:0] == '0) return '0;
    if (RELU_EN && v[SIGN_BIT]) return '0;
    return v;
  endfunction

  // State register; reset aborts any neuron in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)            state_nxt = ST_ACC;
      ST_ACC:  if (in_hs && in_last) state_nxt = ST_FIN;
      ST_FIN:                        state_nxt = ST_OUT;
      ST_OUT:  if (out_ready)        state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: load bias, accumulate terms, latch the activated result once in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc <= bias;
            ovf <= 1'b0;
          end
        end
        ST_ACC: begin
          if (in_hs) begin
            acc <= sat_sum;
            if (add_ovf) ovf <= 1'b1;
          end
        end
        ST_FIN:  out_data <= act_norm(acc);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench: two instances (ReLU on/off) driven in lockstep, checked against an integer model.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low while the result is presented.
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [20:0] bias = '0;
  logic        in_valid = 1'b0;
  logic [20:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        r_in_ready, r_out_valid, r_busy, r_ovf;
  logic [20:0] r_out_data;
  logic        p_in_ready, p_out_valid, p_busy, p_ovf;
  logic [20:0] p_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neuron_accumulator #(.RELU_EN(1'b1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .busy(r_busy), .ovf(r_ovf)
  );

  neuron_accumulator #(.RELU_EN(1'b0)) dut_pass (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
    .busy(p_busy), .ovf(p_ovf)
  );

  // ---------------- reference model: plain signed integers ----------------
  function automatic int sm2int(input logic [20:0] x);
    int m;
    m = int'({12'd0, x[19:0]});
    return x[20] ? -m : m;
  endfunction

  function automatic logic [20:0] int2sm(input int v);
    if (v < 0) return {1'b1, 20'(-v)};
    return {1'b0, 20'(v)};
  endfunction

  task automatic model(input logic [20:0] b, input int n, input logic [20:0] t [8],
                       output logic [20:0] o_relu, output logic [20:0] o_pass, output logic o_ovf);
    int v;
    v = sm2int(b);
    o_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = v + sm2int(t[i]);
      if (v > 1048575)       begin v = 1048575;  o_ovf = 1'b1; end
      else if (v < -1048575) begin v = -1048575; o_ovf = 1'b1; end
    end
    o_pass = int2sm(v);
    o_relu = (v < 0) ? 21'h0 : int2sm(v);
  endtask

  function automatic logic [20:0] rand_sm();
    logic [19:0] m;
    case ($urandom_range(0, 2))
      0:       m = 20'($urandom_range(0, 255));
      1:       m = 20'($urandom_range(32'h000FFF00, 32'h000FFFFF));
      default: m = 20'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), m};
  endfunction

  // ---------------- stimulus driver (no checking here) ----------------
  // Called at a negedge with the DUTs idle. lat counts cycles from the cycle carrying the
  // last term to the first cycle with out_valid high; -1 means out_valid never came.
  task automatic drive_neuron(input logic [20:0] b, input int n, input logic [20:0] t [8], input bit gaps,
                              output logic [20:0] o_r, output logic [20:0] o_p,
                              output logic ov_r, output logic ov_p, output int lat, output logic busy_after);
    start = 1'b1; bias = b;
    @(negedge clk);
    start = 1'b0; bias = 21'($urandom);
    busy_after = r_busy & p_busy;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1; in_data = t[i]; in_last = (i == n - 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 21'($urandom);
    lat = 1;
    while (!r_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!r_out_valid) lat = -1;
    o_r = r_out_data; o_p = p_out_data; ov_r = r_ovf; ov_p = p_ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if ({r_in_ready, r_out_valid, r_busy, r_ovf, r_out_data} !== 25'h0) begin
      n_fail++; $display("FAIL reset_relu_outputs: got %h want 0", {r_in_ready, r_out_valid, r_busy, r_ovf, r_out_data});
    end
    n_checks++;
    if ({p_in_ready, p_out_valid, p_busy, p_ovf, p_out_data} !== 25'h0) begin
      n_fail++; $display("FAIL reset_pass_outputs: got %h want 0", {p_in_ready, p_out_valid, p_busy, p_ovf, p_out_data});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({r_in_ready, r_out_valid, r_busy, r_ovf} !== 4'h0) begin
      n_fail++; $display("FAIL reset_idle_after_release: got %b want 0000", {r_in_ready, r_out_valid, r_busy, r_ovf});
    end
  endtask

  task automatic test_basic();
    logic [20:0] t [8];
    logic [20:0] o_r, o_p;
    logic ov_r, ov_p, ba;
    int lat;
    t[0] = 21'h000005; t[1] = 21'h100002;
    drive_neuron(21'h000003, 2, t, 1'b0, o_r, o_p, ov_r, ov_p, lat, ba);
    n_checks++;
    if (ba !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_start: got %b want 1", ba); end
    n_checks++;
    if (o_r !== 21'h000006) begin n_fail++; $display("FAIL basic_out_relu: got %h want 000006", o_r); end
    n_checks++;
    if (o_p !== 21'h000006) begin n_fail++; $display("FAIL basic_out_pass: got %h want 000006", o_p); end
    n_checks++;
    if (ov_r !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", ov_r); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_checks++;
    if (r_busy !== 1'b0 || r_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle_after_handshake: busy %b out_valid %b want 0 0", r_busy, r_out_valid);
    end
  endtask

  task automatic test_negative();
    logic [20:0] t [8];
    logic [20:0] o_r, o_p;
    logic ov_r, ov_p, ba;
    int lat;
    t[0] = 21'h10000A; t[1] = 21'h000004;
    drive_neuron(21'h000000, 2, t, 1'b1, o_r, o_p, ov_r, ov_p, lat, ba);
    n_checks++;
    if (o_r !== 21'h000000) begin n_fail++; $display("FAIL negative_relu: got %h want 000000", o_r); end
    n_checks++;
    if (o_p !== 21'h100006) begin n_fail++; $display("FAIL negative_pass: got %h want 100006", o_p); end
  endtask

  task automatic test_saturation();
    logic [20:0] t [8];
    logic [20:0] o_r, o_p;
    logic ov_r, ov_p, ba;
    int lat;
    t[0] = 21'h000020;
    drive_neuron(21'h0FFFF0, 1, t, 1'b0, o_r, o_p, ov_r, ov_p, lat, ba);
    n_checks++;
    if (o_p !== 21'h0FFFFF) begin n_fail++; $display("FAIL sat_pos_out: got %h want 0FFFFF", o_p); end
    n_checks++;
    if (ov_r !== 1'b1 || ov_p !== 1'b1) begin n_fail++; $display("FAIL sat_pos_ovf: got %b%b want 11", ov_r, ov_p); end
    // negative overflow then partial recovery: ovf must stay set
    t[0] = 21'h100010; t[1] = 21'h000005;
    drive_neuron(21'h1FFFF8, 2, t, 1'b0, o_r, o_p, ov_r, ov_p, lat, ba);
    n_checks++;
    if (o_p !== 21'h1FFFFA) begin n_fail++; $display("FAIL sat_neg_recover_out: got %h want 1FFFFA", o_p); end
    n_checks++;
    if (ov_p !== 1'b1) begin n_fail++; $display("FAIL sat_neg_recover_ovf: got %b want 1", ov_p); end
    t[0] = 21'h000001;
    drive_neuron(21'h000000, 1, t, 1'b0, o_r, o_p, ov_r, ov_p, lat, ba);
    n_checks++;
    if (ov_r !== 1'b0 || o_r !== 21'h000001) begin
      n_fail++; $display("FAIL sat_next_neuron: ovf %b out %h want 0 000001", ov_r, o_r);
    end
  endtask

  task automatic test_cancel();
    logic [20:0] t [8];
    logic [20:0] o_r, o_p;
    logic ov_r, ov_p, ba;
    int lat;
    t[0] = 21'h100007;
    drive_neuron(21'h000007, 1, t, 1'b0, o_r, o_p, ov_r, ov_p, lat, ba);
    n_checks++;
    if (o_p !== 21'h000000) begin n_fail++; $display("FAIL cancel_pass: got %h want 000000", o_p); end
    // negative bias cancelled by a positive term leaves a negative-signed zero in the accumulator
    t[0] = 21'h000009;
    drive_neuron(21'h100009, 1, t, 1'b0, o_r, o_p, ov_r, ov_p, lat, ba);
    n_checks++;
    if (o_p !== 21'h000000) begin n_fail++; $display("FAIL cancel_negzero: got %h want 000000", o_p); end
  endtask

  task automatic test_backpressure();
    logic [20:0] t [8];
    logic [20:0] o_r, o_p;
    logic ov_r, ov_p, ba;
    int lat;
    int wait_cnt;
    start = 1'b1; bias = 21'h000005;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 21'h000003; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    wait_cnt = 0;
    while (!r_out_valid && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    n_checks++;
    if (r_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_timeout: got %b want 1", r_out_valid); end
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; bias = 21'($urandom);
      in_valid = 1'b1; in_data = 21'($urandom); in_last = 1'b1;
      @(negedge clk);
      n_checks++;
      if (r_out_valid !== 1'b1 || r_out_data !== 21'h000008 || p_out_data !== 21'h000008) begin
        n_fail++; $display("FAIL bp_hold_c%0d: valid %b data %h/%h want 1 000008", c, r_out_valid, r_out_data, p_out_data);
      end
      n_checks++;
      if (r_in_ready !== 1'b0 || r_ovf !== 1'b0 || r_busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_ctrl_c%0d: in_ready %b ovf %b busy %b want 0 0 1", c, r_in_ready, r_ovf, r_busy);
      end
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (r_busy !== 1'b0 || r_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: busy %b out_valid %b want 0 0", r_busy, r_out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (r_busy !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored: busy %b want 0", r_busy); end
    t[0] = 21'h000002;
    drive_neuron(21'h000001, 1, t, 1'b0, o_r, o_p, ov_r, ov_p, lat, ba);
    n_checks++;
    if (o_r !== 21'h000003) begin n_fail++; $display("FAIL bp_next_neuron: got %h want 000003", o_r); end
  endtask

  task automatic test_mid_reset();
    logic [20:0] t [8];
    logic [20:0] o_r, o_p;
    logic ov_r, ov_p, ba;
    int lat;
    start = 1'b1; bias = 21'h000100;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 21'h000005; in_last = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({r_in_ready, r_out_valid, r_busy, r_ovf, r_out_data} !== 25'h0) begin
      n_fail++; $display("FAIL midreset_relu: got %h want 0", {r_in_ready, r_out_valid, r_busy, r_ovf, r_out_data});
    end
    n_checks++;
    if ({p_in_ready, p_out_valid, p_busy, p_ovf, p_out_data} !== 25'h0) begin
      n_fail++; $display("FAIL midreset_pass: got %h want 0", {p_in_ready, p_out_valid, p_busy, p_ovf, p_out_data});
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t[0] = 21'h000001;
    drive_neuron(21'h000001, 1, t, 1'b0, o_r, o_p, ov_r, ov_p, lat, ba);
    n_checks++;
    if (o_p !== 21'h000002 || o_r !== 21'h000002) begin
      n_fail++; $display("FAIL midreset_fresh: got %h/%h want 000002", o_r, o_p);
    end
  endtask

  task automatic test_random();
    logic [20:0] t [8];
    logic [20:0] o_r, o_p, e_r, e_p, b;
    logic ov_r, ov_p, e_ov, ba;
    int lat, n;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, 8);
      b = rand_sm();
      for (int i = 0; i < 8; i++) t[i] = rand_sm();
      model(b, n, t, e_r, e_p, e_ov);
      drive_neuron(b, n, t, 1'b1, o_r, o_p, ov_r, ov_p, lat, ba);
      n_checks++;
      if (o_r !== e_r) begin n_fail++; $display("FAIL rand%0d_relu: got %h want %h", k, o_r, e_r); end
      n_checks++;
      if (o_p !== e_p) begin n_fail++; $display("FAIL rand%0d_pass: got %h want %h", k, o_p, e_p); end
      n_checks++;
      if (ov_r !== e_ov || ov_p !== e_ov) begin n_fail++; $display("FAIL rand%0d_ovf: got %b%b want %b", k, ov_r, ov_p, e_ov); end
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want 2", k, lat); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_cancel();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
